// File: rtl/wb_banco_registradores_pkg.sv
// Shared sizing constants and helpers for the WB/ID register bank.
package wb_banco_registradores_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int PEND_W  = 2;

  // R0 is hardwired to zero and never tracked by the scoreboard
  localparam int R0_ADDR = 0;

  // Saturation value of a pending-write counter
  function automatic int pend_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/wb_banco_registradores_scoreboard.sv
// Per-register pending-write counters, operand readiness and sticky error.
module wb_scoreboard #(
  parameter int ADDR_W = wb_banco_registradores_pkg::ADDR_W,
  parameter int PEND_W = wb_banco_registradores_pkg::PEND_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_escreve,
  input  logic [ADDR_W-1:0] wb_endereco,
  input  logic [ADDR_W-1:0] id_reg_a,
  input  logic [ADDR_W-1:0] id_reg_b,
  input  logic              reserva,
  input  logic [ADDR_W-1:0] reserva_end,
  output logic              stall,
  output logic              erro_sb
);
  import wb_banco_registradores_pkg::*;

  localparam int                NREG     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R0       = ADDR_W'(R0_ADDR);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(pend_max(PEND_W));
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] r_pend [NREG];
  logic              r_erro;

  logic              w_rdy_a, w_rdy_b;
  logic              w_inc, w_dec;
  logic [NREG-1:0]   w_inc_vec, w_dec_vec;
  logic [PEND_W-1:0] w_pend_nxt [NREG];
  logic              w_erro_set;

  // A source is ready when untracked, idle, or its last pending write lands this cycle
  always_comb begin
    w_rdy_a = (id_reg_a == R0) || (r_pend[id_reg_a] == '0) ||
              (r_pend[id_reg_a] == PEND_ONE && wb_escreve && wb_endereco == id_reg_a);
    w_rdy_b = (id_reg_b == R0) || (r_pend[id_reg_b] == '0) ||
              (r_pend[id_reg_b] == PEND_ONE && wb_escreve && wb_endereco == id_reg_b);
    stall   = !(w_rdy_a && w_rdy_b);
  end

  // Reservation only counts when the instruction actually issues (no stall)
  always_comb begin
    w_inc     = reserva && !stall && (reserva_end != R0);
    w_dec     = wb_escreve && (wb_endereco != R0);
    w_inc_vec = w_inc ? (NREG'(1) << reserva_end) : '0;
    w_dec_vec = w_dec ? (NREG'(1) << wb_endereco) : '0;
  end

  // Next counter values; inc and dec on the same register cancel out
  always_comb begin
    w_erro_set = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      w_pend_nxt[i] = r_pend[i];
      if (w_inc_vec[i] && !w_dec_vec[i]) begin
        if (r_pend[i] == PEND_MAX) w_erro_set = 1'b1;
        else                       w_pend_nxt[i] = r_pend[i] + PEND_ONE;
      end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
        if (r_pend[i] == '0) w_erro_set = 1'b1;
        else                 w_pend_nxt[i] = r_pend[i] - PEND_ONE;
      end
    end
  end

  // Counter state and sticky error; only reset clears the error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
      r_erro <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) r_pend[i] <= w_pend_nxt[i];
      if (w_erro_set) r_erro <= 1'b1;
    end
  end

  assign erro_sb = r_erro;

endmodule

// File: rtl/wb_banco_registradores.sv
// 32x32 register bank between WB and ID: write port, two bypassed read ports,
// pending-write scoreboard driving the ID stall.
module wb_banco_registradores #(
  parameter int DATA_W = wb_banco_registradores_pkg::DATA_W,
  parameter int ADDR_W = wb_banco_registradores_pkg::ADDR_W,
  parameter int PEND_W = wb_banco_registradores_pkg::PEND_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_escreve,
  input  logic [ADDR_W-1:0] wb_endereco,
  input  logic [DATA_W-1:0] wb_dado,
  input  logic [ADDR_W-1:0] id_reg_a,
  input  logic [ADDR_W-1:0] id_reg_b,
  input  logic              reserva,
  input  logic [ADDR_W-1:0] reserva_end,
  output logic [DATA_W-1:0] dado_a,
  output logic [DATA_W-1:0] dado_b,
  output logic              stall,
  output logic              erro_sb
);
  import wb_banco_registradores_pkg::*;

  localparam int                NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R0   = ADDR_W'(R0_ADDR);

  logic [DATA_W-1:0] r_regs [NREG];
  logic              w_we;

  assign w_we = wb_escreve && (wb_endereco != R0);

  // Register array; R0 is never written so it stays at its reset value of zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[wb_endereco] <= wb_dado;
    end
  end

  // Read ports: R0 reads zero, same-cycle write data bypasses the array
  always_comb begin
    if (id_reg_a == R0)                                dado_a = '0;
    else if (wb_escreve && wb_endereco == id_reg_a)    dado_a = wb_dado;
    else                                               dado_a = r_regs[id_reg_a];
    if (id_reg_b == R0)                                dado_b = '0;
    else if (wb_escreve && wb_endereco == id_reg_b)    dado_b = wb_dado;
    else                                               dado_b = r_regs[id_reg_b];
  end

  wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .PEND_W (PEND_W)
  ) u_sb (
    .clock       (clock),
    .reset       (reset),
    .wb_escreve  (wb_escreve),
    .wb_endereco (wb_endereco),
    .id_reg_a    (id_reg_a),
    .id_reg_b    (id_reg_b),
    .reserva     (reserva),
    .reserva_end (reserva_end),
    .stall       (stall),
    .erro_sb     (erro_sb)
  );

endmodule

// File: tb/tb_wb_banco_registradores.sv
// Directed bench for the WB/ID register bank and its scoreboard.
module tb_wb_banco_registradores;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_escreve;
  logic [4:0]  wb_endereco;
  logic [31:0] wb_dado;
  logic [4:0]  id_reg_a, id_reg_b;
  logic        reserva;
  logic [4:0]  reserva_end;
  logic [31:0] dado_a, dado_b;
  logic        stall, erro_sb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  wb_banco_registradores dut (
    .clock       (clock),
    .reset       (reset),
    .wb_escreve  (wb_escreve),
    .wb_endereco (wb_endereco),
    .wb_dado     (wb_dado),
    .id_reg_a    (id_reg_a),
    .id_reg_b    (id_reg_b),
    .reserva     (reserva),
    .reserva_end (reserva_end),
    .dado_a      (dado_a),
    .dado_b      (dado_b),
    .stall       (stall),
    .erro_sb     (erro_sb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wb_escreve = 1'b0; wb_endereco = '0; wb_dado = '0;
    reserva = 1'b0; reserva_end = '0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_escreve = 1'b1; wb_endereco = a; wb_dado = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    reserva = 1'b1; reserva_end = a;
  endtask

  initial begin
    idle();
    id_reg_a = 5'd5; id_reg_b = 5'd0;
    reset = 1'b1;
    #2;
    check("rst_dado_a", dado_a, 32'h0);
    check("rst_dado_b", dado_b, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_erro", {31'h0, erro_sb}, 32'h0);
    #10 reset = 1'b0;
    tick();

    // Write R7 (reserved first so the release is legal) with same-cycle bypass
    id_reg_a = 5'd0;
    rsv(5'd7); tick(); idle();
    wb(5'd7, 32'hDEADBEEF); id_reg_a = 5'd7; #1;
    check("bypass_a", dado_a, 32'hDEADBEEF);
    check("bypass_stall", {31'h0, stall}, 32'h0);
    tick(); idle(); #1;
    check("stored_a", dado_a, 32'hDEADBEEF);
    // R0 write discarded
    wb(5'd0, 32'h1234); id_reg_a = 5'd0; #1;
    check("r0_bypass", dado_a, 32'h0);
    tick(); idle(); #1;
    check("r0_read", dado_a, 32'h0);
    check("r0_no_err", {31'h0, erro_sb}, 32'h0);

    // Hazard on R3
    rsv(5'd3); tick(); idle();
    id_reg_b = 5'd3; #1;
    check("haz_stall_c1", {31'h0, stall}, 32'h1);
    tick(); #1;
    check("haz_stall_c2", {31'h0, stall}, 32'h1);
    tick();
    wb(5'd3, 32'h55); #1;
    check("haz_release_stall", {31'h0, stall}, 32'h0);
    check("haz_bypass_b", dado_b, 32'h55);
    tick(); idle(); #1;
    check("haz_after_stall", {31'h0, stall}, 32'h0);
    check("haz_after_b", dado_b, 32'h55);
    id_reg_b = 5'd0;

    // Two writes in flight to R4
    rsv(5'd4); tick(); tick(); idle();
    id_reg_a = 5'd4; #1;
    check("dbl_stall", {31'h0, stall}, 32'h1);
    wb(5'd4, 32'h44); #1;
    check("dbl_first_wb", {31'h0, stall}, 32'h1);
    tick();
    wb(5'd4, 32'h45); #1;
    check("dbl_second_wb", {31'h0, stall}, 32'h0);
    check("dbl_second_a", dado_a, 32'h45);
    tick(); idle(); #1;
    check("dbl_done", {31'h0, stall}, 32'h0);
    id_reg_a = 5'd0;

    // Simultaneous reserve and release on R9
    rsv(5'd9); tick(); idle();
    rsv(5'd9); wb(5'd9, 32'h99); tick(); idle();
    id_reg_a = 5'd9; #1;
    check("simul_pend_kept", {31'h0, stall}, 32'h1);
    check("simul_no_err", {31'h0, erro_sb}, 32'h0);
    // Reservation of R10 while stalled must be ignored
    rsv(5'd10); tick(); idle();
    id_reg_a = 5'd10; #1;
    check("rsv_in_stall", {31'h0, stall}, 32'h0);
    id_reg_a = 5'd9;
    wb(5'd9, 32'h9A); #1;
    check("r9_release", {31'h0, stall}, 32'h0);
    tick(); idle(); #1;
    check("r9_idle", {31'h0, stall}, 32'h0);
    check("r9_no_err", {31'h0, erro_sb}, 32'h0);

    // Underflow: WB to unreserved R12 still writes
    id_reg_a = 5'd0;
    wb(5'd12, 32'h00C0FFEE); tick(); idle();
    id_reg_a = 5'd12; #1;
    check("unf_err", {31'h0, erro_sb}, 32'h1);
    check("unf_written", dado_a, 32'h00C0FFEE);

    // Overflow: four reservations of R2 saturate at 3
    id_reg_a = 5'd0;
    rsv(5'd2); tick(); tick(); tick(); tick(); idle();
    id_reg_a = 5'd2; #1;
    check("ovf_stall", {31'h0, stall}, 32'h1);
    wb(5'd2, 32'h21); tick();
    wb(5'd2, 32'h22); #1;
    check("ovf_wb2_stall", {31'h0, stall}, 32'h1);
    tick();
    wb(5'd2, 32'h23); #1;
    check("ovf_wb3_stall", {31'h0, stall}, 32'h0);
    tick(); idle(); #1;
    check("ovf_drained", {31'h0, stall}, 32'h0);
    check("ovf_err", {31'h0, erro_sb}, 32'h1);

    // Async reset mid-cycle with a pending write on R5
    id_reg_a = 5'd0;
    rsv(5'd5); tick(); idle();
    id_reg_a = 5'd5; #1;
    check("pre_rst_stall", {31'h0, stall}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_stall", {31'h0, stall}, 32'h0);
    check("async_rst_erro", {31'h0, erro_sb}, 32'h0);
    id_reg_a = 5'd12; #1;
    check("async_rst_regs", dado_a, 32'h0);
    #10 reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
